// File: rtl/hit_reaction_ctrl.sv
// hit_reaction_ctrl: hit/block stun FSM with health and invulnerability; define GUARD_METER_EN for a regenerating guard meter
module hit_reaction_ctrl #(
  parameter int MAX_HEALTH         = 3,
  parameter int HITSTUN_FRAMES     = 20,
  parameter int BLOCKSTUN_FRAMES   = 10,
  parameter int INVULN_FRAMES      = 30,
  parameter int GUARD_MAX          = 3,
  parameter int GUARD_REGEN_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       round_start,
  input  logic       got_hit,
  input  logic       got_blocked,
  output logic [2:0] health,
  output logic       hurtbox_enable,
  output logic       in_hitstun,
  output logic       in_blockstun,
  output logic       ko,
  output logic       hit_pulse,
  output logic       block_pulse,
  output logic [1:0] guard_level
);
  typedef enum logic [2:0] {IDLE, HITSTUN, BLOCKSTUN, INVULN, KO} state_t;
  localparam logic [2:0] HMAX = 3'(MAX_HEALTH);
  localparam logic [7:0] HS = 8'(HITSTUN_FRAMES);
  localparam logic [7:0] BS = 8'(BLOCKSTUN_FRAMES);
  localparam logic [7:0] IV = 8'(INVULN_FRAMES);
  if (MAX_HEALTH < 1 || MAX_HEALTH > 7 || HITSTUN_FRAMES < 1 || HITSTUN_FRAMES > 255 ||
      BLOCKSTUN_FRAMES < 1 || BLOCKSTUN_FRAMES > 255 || INVULN_FRAMES < 1 || INVULN_FRAMES > 255 ||
      GUARD_MAX < 1 || GUARD_MAX > 3 || GUARD_REGEN_FRAMES < 1 || GUARD_REGEN_FRAMES > 255) begin : g_bad_param
    $error("hit_reaction_ctrl: parameter out of range");
  end
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] health_q, health_d;
  logic       hit_prev_q, blk_prev_q;
  logic       hit_pulse_q, hit_pulse_d, block_pulse_q, block_pulse_d;
  logic       hit_ev, blk_ev, can_react, brk, brk_ev, take_hit, take_blk;
  assign hit_ev    = got_hit & ~hit_prev_q;
  assign blk_ev    = got_blocked & ~blk_prev_q;
  assign can_react = state_q == IDLE || state_q == BLOCKSTUN;
  assign brk_ev    = can_react & blk_ev & ~hit_ev & brk;
  assign take_hit  = can_react & hit_ev | brk_ev;
  assign take_blk  = can_react & blk_ev & ~hit_ev & ~brk;
`ifdef GUARD_METER_EN
  localparam logic [1:0] GMAX = 2'(GUARD_MAX);
  localparam logic [7:0] RG   = 8'(GUARD_REGEN_FRAMES - 1);
  logic [1:0] guard_q, guard_d;
  logic [7:0] regen_q, regen_d;
  assign brk = guard_q == 2'd1;
  always_comb begin
    guard_d = guard_q;
    regen_d = '0;
    if (round_start || brk_ev) guard_d = GMAX;
    else if (take_blk) guard_d = guard_q - 2'd1;
    else if (state_q == IDLE && !take_hit) begin
      regen_d = (frame_tick && regen_q == RG) ? 8'd0 : regen_q + {7'd0, frame_tick};
      guard_d = (frame_tick && regen_q == RG && guard_q != GMAX) ? guard_q + 2'd1 : guard_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      guard_q <= GMAX;
      regen_q <= '0;
    end else begin
      guard_q <= guard_d;
      regen_q <= regen_d;
    end
  assign guard_level = guard_q;
`else
  assign brk         = 1'b0;
  assign guard_level = 2'd0;
`endif
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    health_d      = health_q;
    hit_pulse_d   = 1'b0;
    block_pulse_d = 1'b0;
    if (round_start) begin
      state_d  = IDLE;
      cnt_d    = '0;
      health_d = HMAX;
    end else if (take_hit) begin
      health_d    = health_q - {2'd0, health_q != 3'd0};
      hit_pulse_d = 1'b1;
      state_d     = health_d == 3'd0 ? KO : HITSTUN;
      cnt_d       = health_d == 3'd0 ? 8'd0 : HS;
    end else if (take_blk) begin
      block_pulse_d = 1'b1;
      state_d       = BLOCKSTUN;
      cnt_d         = BS;
    end else if (frame_tick && cnt_q != 8'd0) begin
      state_d = cnt_q != 8'd1 ? state_q : state_q == HITSTUN ? INVULN : IDLE;
      cnt_d   = cnt_q != 8'd1 ? cnt_q - 8'd1 : state_q == HITSTUN ? IV : 8'd0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      health_q      <= HMAX;
      hit_prev_q    <= 1'b0;
      blk_prev_q    <= 1'b0;
      hit_pulse_q   <= 1'b0;
      block_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      health_q      <= health_d;
      hit_prev_q    <= got_hit;
      blk_prev_q    <= got_blocked;
      hit_pulse_q   <= hit_pulse_d;
      block_pulse_q <= block_pulse_d;
    end
  assign health         = health_q;
  assign hurtbox_enable = can_react;
  assign in_hitstun     = state_q == HITSTUN;
  assign in_blockstun   = state_q == BLOCKSTUN;
  assign ko             = state_q == KO;
  assign hit_pulse      = hit_pulse_q;
  assign block_pulse    = block_pulse_q;
endmodule

// File: tb/tb_hit_reaction_ctrl.sv
// tb_hit_reaction_ctrl: vector table, directed corner sequences and random stimulus against a frames-remaining model
module tb_hit_reaction_ctrl;
  localparam int HS = 20, BS = 10, IV = 30, RGF = 60, HMAX = 3, GMX = 3;
`ifdef GUARD_METER_EN
  localparam bit GM = 1'b1;
`else
  localparam bit GM = 1'b0;
`endif
  localparam logic [1:0] GV = GM ? 2'(GMX) : 2'd0;
  localparam logic [1:0] G2 = GM ? 2'd2 : 2'd0;
  localparam logic [1:0] G1 = GM ? 2'd1 : 2'd0;
  logic clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0, round_start = 1'b0, got_hit = 1'b0, got_blocked = 1'b0;
  logic [2:0] health;
  logic hurtbox_enable, in_hitstun, in_blockstun, ko, hit_pulse, block_pulse;
  logic [1:0] guard_level;
  logic [11:0] act;
  int total = 0, bad = 0;
  int m_health, m_hit, m_blk, m_inv, m_guard, m_regen;
  bit m_hp, m_bp, m_ph, m_pb;
  typedef struct {bit ft, rs, gh, gb; logic [11:0] exp;} vec_t;
  vec_t tbl[13];
  hit_reaction_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .round_start(round_start),
    .got_hit(got_hit), .got_blocked(got_blocked), .health(health), .hurtbox_enable(hurtbox_enable),
    .in_hitstun(in_hitstun), .in_blockstun(in_blockstun), .ko(ko), .hit_pulse(hit_pulse),
    .block_pulse(block_pulse), .guard_level(guard_level)
  );
  always #5 clk = ~clk;
  assign act = {health, hurtbox_enable, in_hitstun, in_blockstun, ko, hit_pulse, block_pulse, guard_level};
  function automatic logic [11:0] o(int h, bit hb, bit hs, bit bs, bit k, bit hp, bit bp, logic [1:0] g);
    return {3'(h), hb, hs, bs, k, hp, bp, g};
  endfunction
  function automatic logic [11:0] model_out();
    return o(m_health, !(m_hit > 0 || m_inv > 0 || m_health == 0), m_hit > 0, m_blk > 0, m_health == 0,
             m_hp, m_bp, GM ? 2'(m_guard) : 2'd0);
  endfunction
  task automatic chk(input string nm, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got h=%0d hb/hs/bs/ko/hp/bp=%b g=%0d want h=%0d hb/hs/bs/ko/hp/bp=%b g=%0d",
               nm, $time, act[11:9], act[8:3], act[1:0], exp[11:9], exp[8:3], exp[1:0]);
    end
  endtask
  task automatic model_reset();
    m_health = HMAX; m_hit = 0; m_blk = 0; m_inv = 0; m_guard = GM ? GMX : 0; m_regen = 0;
    m_hp = 0; m_bp = 0; m_ph = 0; m_pb = 0;
  endtask
  task automatic model_step(input bit ft, input bit rs, input bit gh, input bit gb);
    bit eh, eb, idle, open;
    int r;
    eh = gh && !m_ph;
    eb = gb && !m_pb;
    idle = m_health > 0 && m_hit == 0 && m_blk == 0 && m_inv == 0;
    open = idle || m_blk > 0;
    r = m_regen;
    m_regen = 0; m_hp = 0; m_bp = 0;
    if (rs) begin
      m_health = HMAX; m_hit = 0; m_blk = 0; m_inv = 0; m_guard = GM ? GMX : 0;
    end else if (open && (eh || (eb && GM && m_guard == 1))) begin
      if (!eh) m_guard = GMX;
      m_health = m_health > 0 ? m_health - 1 : 0;
      m_hp = 1; m_blk = 0;
      m_hit = m_health > 0 ? HS : 0;
    end else if (open && eb) begin
      m_bp = 1; m_blk = BS;
      if (GM) m_guard--;
    end else begin
      if (ft) begin
        if (m_hit > 0) begin
          m_hit--;
          if (m_hit == 0) m_inv = IV;
        end else if (m_inv > 0) m_inv--;
        else if (m_blk > 0) m_blk--;
      end
      if (idle && GM) begin
        r += int'(ft);
        if (r == RGF) begin
          r = 0;
          if (m_guard < GMX) m_guard++;
        end
        m_regen = r;
      end
    end
    m_ph = gh; m_pb = gb;
  endtask
  task automatic drive(input bit ft, input bit rs, input bit gh, input bit gb);
    frame_tick = ft; round_start = rs; got_hit = gh; got_blocked = gb;
    model_step(ft, rs, gh, gb);
    @(negedge clk);
  endtask
  task automatic cyc(input string nm, input bit ft, input bit rs, input bit gh, input bit gb);
    drive(ft, rs, gh, gb);
    chk(nm, model_out());
  endtask
  task automatic ticks(input int n, input bit gh, input bit gb);
    for (int i = 0; i < n; i++) cyc("tick", 1'b1, 1'b0, gh, gb);
  endtask
  task automatic do_reset(input bit gh);
    rst_n = 1'b0; frame_tick = 1'b0; round_start = 1'b0; got_hit = gh; got_blocked = 1'b0;
    model_reset();
    #1 chk("reset_async", o(3, 1, 0, 0, 0, 0, 0, GV));
    @(negedge clk);
    chk("reset_hold", o(3, 1, 0, 0, 0, 0, 0, GV));
    rst_n = 1'b1;
  endtask
  initial begin
    tbl[0]  = '{0, 0, 0, 0, o(3, 1, 0, 0, 0, 0, 0, GV)};
    tbl[1]  = '{0, 0, 1, 0, o(2, 0, 1, 0, 0, 1, 0, GV)};
    tbl[2]  = '{0, 0, 1, 0, o(2, 0, 1, 0, 0, 0, 0, GV)};
    tbl[3]  = '{1, 0, 0, 0, o(2, 0, 1, 0, 0, 0, 0, GV)};
    tbl[4]  = '{0, 0, 1, 0, o(2, 0, 1, 0, 0, 0, 0, GV)};
    tbl[5]  = '{0, 1, 0, 0, o(3, 1, 0, 0, 0, 0, 0, GV)};
    tbl[6]  = '{0, 0, 0, 1, o(3, 1, 0, 1, 0, 0, 1, G2)};
    tbl[7]  = '{0, 0, 1, 1, o(2, 0, 1, 0, 0, 1, 0, G2)};
    tbl[8]  = '{0, 1, 1, 0, o(3, 1, 0, 0, 0, 0, 0, GV)};
    tbl[9]  = '{0, 1, 0, 1, o(3, 1, 0, 0, 0, 0, 0, GV)};
    tbl[10] = '{0, 0, 0, 0, o(3, 1, 0, 0, 0, 0, 0, GV)};
    tbl[11] = '{0, 0, 1, 1, o(2, 0, 1, 0, 0, 1, 0, GV)};
    tbl[12] = '{0, 1, 0, 0, o(3, 1, 0, 0, 0, 0, 0, GV)};
    @(negedge clk);
    do_reset(1'b0);
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].ft, tbl[i].rs, tbl[i].gh, tbl[i].gb);
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end
    cyc("hit", 0, 0, 1, 0);
    chk("hit_first", o(2, 0, 1, 0, 0, 1, 0, GV));
    cyc("hold", 0, 0, 1, 0);
    chk("hit_pulse_once", o(2, 0, 1, 0, 0, 0, 0, GV));
    ticks(HS - 1, 1, 0);
    chk("hitstun_last", o(2, 0, 1, 0, 0, 0, 0, GV));
    ticks(1, 1, 0);
    chk("invuln_enter", o(2, 0, 0, 0, 0, 0, 0, GV));
    ticks(IV - 1, 1, 0);
    chk("invuln_last", o(2, 0, 0, 0, 0, 0, 0, GV));
    ticks(1, 1, 0);
    chk("idle_after_invuln", o(2, 1, 0, 0, 0, 0, 0, GV));
    cyc("rel", 0, 0, 0, 0);
    cyc("hit2", 0, 0, 1, 0);
    ticks(HS + IV, 0, 0);
    chk("idle_h1", o(1, 1, 0, 0, 0, 0, 0, GV));
    cyc("hit3", 0, 0, 1, 0);
    chk("ko_enter", o(0, 0, 0, 0, 1, 1, 0, GV));
    cyc("rel", 0, 0, 0, 0);
    ticks(5, 0, 0);
    cyc("hit_in_ko", 0, 0, 1, 0);
    cyc("blk_in_ko", 0, 0, 0, 1);
    chk("ko_sticky", o(0, 0, 0, 0, 1, 0, 0, GV));
    cyc("round", 0, 1, 0, 0);
    chk("round_restart", o(3, 1, 0, 0, 0, 0, 0, GV));
    cyc("blk1", 0, 0, 0, 1);
    chk("block_enter", o(3, 1, 0, 1, 0, 0, 1, G2));
    ticks(5, 0, 0);
    cyc("blk2", 0, 0, 0, 1);
    chk("block_reload", o(3, 1, 0, 1, 0, 0, 1, G1));
    ticks(BS - 1, 0, 1);
    chk("blockstun_last", o(3, 1, 0, 1, 0, 0, 0, G1));
    ticks(1, 0, 1);
    chk("blockstun_end", o(3, 1, 0, 0, 0, 0, 0, G1));
    cyc("round", 0, 1, 0, 0);
    cyc("blk", 0, 0, 0, 1);
    cyc("hit_in_blk", 0, 0, 1, 1);
    chk("hit_in_blockstun", o(2, 0, 1, 0, 0, 1, 0, G2));
    if (GM) begin
      cyc("round", 0, 1, 0, 0);
      cyc("g1", 0, 0, 0, 1);
      ticks(BS, 0, 0);
      cyc("g2", 0, 0, 0, 1);
      ticks(BS, 0, 0);
      cyc("g3", 0, 0, 0, 1);
      chk("guard_break", o(2, 0, 1, 0, 0, 1, 0, 2'd3));
      cyc("round", 0, 1, 0, 0);
      cyc("g1", 0, 0, 0, 1);
      ticks(BS, 0, 0);
      ticks(RGF - 1, 0, 0);
      chk("regen_before", o(3, 1, 0, 0, 0, 0, 0, 2'd2));
      ticks(1, 0, 0);
      chk("regen_after", o(3, 1, 0, 0, 0, 0, 0, 2'd3));
    end
    cyc("round", 0, 1, 0, 0);
    cyc("hit", 0, 0, 1, 0);
    ticks(3, 1, 0);
    do_reset(1'b1);
    cyc("held_release", 0, 0, 1, 0);
    chk("hit_across_reset", o(2, 0, 1, 0, 0, 1, 0, GV));
    for (int i = 0; i < 3000; i++)
      cyc("rand", $urandom_range(3, 0) != 0, $urandom_range(399, 0) == 0,
          ($urandom_range(3, 0) == 0) ? !got_hit : got_hit,
          ($urandom_range(3, 0) == 0) ? !got_blocked : got_blocked);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hit_reaction_ctrl.md
HIT_REACTION_CTRL -- requirements
Module: hit_reaction_ctrl

Interface
REQ-001 SHALL have parameter MAX_HEALTH, default 3, starting health per round (legal 1..7).
REQ-002 SHALL have parameter HITSTUN_FRAMES, default 20, hitstun length in frames (legal 1..255).
REQ-003 SHALL have parameter BLOCKSTUN_FRAMES, default 10, blockstun length in frames (legal 1..255).
REQ-004 SHALL have parameter INVULN_FRAMES, default 30, post-hitstun invulnerability length in frames (legal 1..255).
REQ-005 SHALL have parameter GUARD_MAX, default 3, full guard meter value (legal 1..3).
REQ-006 SHALL have parameter GUARD_REGEN_FRAMES, default 60, idle frames per guard point regained (legal 1..255).
REQ-007 clk  input  1  single system clock, all state on rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 frame_tick  input  1  one-cycle pulse per game frame; all frame counters advance only on it.
REQ-010 round_start  input  1  one-cycle pulse reinitialising the round.
REQ-011 got_hit  input  1  level from collision stage, high while the hitbox overlaps an unblocked hurtbox.
REQ-012 got_blocked  input  1  level from collision stage, high while the hitbox overlaps a blocking hurtbox.
REQ-013 health  output  3  remaining health.
REQ-014 hurtbox_enable  output  1  drives the collision stage target hurtbox-active input.
REQ-015 in_hitstun, in_blockstun, ko  output  1 each  state flags.
REQ-016 hit_pulse, block_pulse  output  1 each  one-cycle strobes on accepted events.
REQ-017 guard_level  output  2  current guard meter.

Function
REQ-018 SHALL edge-detect got_hit and got_blocked with registers; an event is input high while its registered copy is low.
REQ-019 SHALL implement states IDLE, HITSTUN, BLOCKSTUN, INVULN, KO; outputs registered, updating the cycle after the event edge.
REQ-020 Hit event in IDLE or BLOCKSTUN SHALL decrement health (saturating at 0), pulse hit_pulse, and enter KO if resulting health is 0, else HITSTUN with counter loaded to HITSTUN_FRAMES.
REQ-021 Block event in IDLE SHALL pulse block_pulse and enter BLOCKSTUN with counter loaded to BLOCKSTUN_FRAMES; block event in BLOCKSTUN SHALL reload the counter and pulse block_pulse.
REQ-022 Events in HITSTUN, INVULN or KO SHALL be ignored (no pulse, no health change).
REQ-023 Hit and block events in the same cycle SHALL be treated as hit only.
REQ-024 Counter SHALL decrement on frame_tick; a tick with counter equal to 1 SHALL end the state: HITSTUN->INVULN (load INVULN_FRAMES), INVULN->IDLE, BLOCKSTUN->IDLE.
REQ-025 hurtbox_enable SHALL be 1 in IDLE and BLOCKSTUN, 0 in HITSTUN, INVULN, KO.
REQ-026 in_hitstun=1 only in HITSTUN, in_blockstun=1 only in BLOCKSTUN, ko=1 only in KO; KO is sticky until round_start.
REQ-027 round_start SHALL, with priority over any simultaneous event, set health=MAX_HEALTH, state IDLE, counters 0, guard_level=GUARD_MAX (0 without macro), suppressing pulses that cycle.

Reset
REQ-028 While rst_n=0: state IDLE, health=MAX_HEALTH, counters 0, edge registers 0, hurtbox_enable=1, all flags and pulses 0, guard_level=GUARD_MAX (0 without macro).
REQ-029 Reset asserted mid-stun SHALL abort immediately; a got_hit level held across reset release SHALL count as one event on the first clock after release.

Configuration
REQ-030 With GUARD_METER_EN defined: each accepted block event decrements guard_level; a block event with guard_level=1 SHALL instead be processed as a hit event (guard break, REQ-020) and reload guard_level to GUARD_MAX; in IDLE guard_level SHALL increment by 1 (saturating at GUARD_MAX) every GUARD_REGEN_FRAMES frame_ticks, the regen counter clearing on leaving IDLE.
REQ-031 Without GUARD_METER_EN: guard_level SHALL be constant 0, no regen logic, blocks never convert to hits.

Verification
REQ-032 Reset, got_hit rising in IDLE -> next cycle health=2, hit_pulse=1 for one cycle, in_hitstun=1, hurtbox_enable=0.
REQ-033 After hit, 20 frame_ticks -> INVULN; 30 further ticks -> IDLE, hurtbox_enable=1; got_hit held high throughout -> no second decrement.
REQ-034 Three separated hits from health 3 -> health=0, ko=1 after third; further hits ignored; round_start -> health=3, IDLE.
REQ-035 got_blocked edge, second edge after 5 ticks -> blockstun ends 10 ticks after second edge; got_hit during blockstun -> health decrements, HITSTUN.
REQ-036 GUARD_METER_EN, GUARD_MAX=3: three block events -> guard 2, 1, then third is hit (health 3->2, guard=3); 60 idle ticks at guard 2 -> guard 3.
